// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing the 4-bit HD44780 bus between byte-write requesters.
// Each granted byte is sent as two nibbles (setup / E pulse / hold), followed by an execution wait.
module lcd_write_arbiter #(
   parameter int FREQ         = 50000000,
   parameter int N_REQ        = 3,
   parameter int SETUP_CYC    = 2,
   parameter int HOLD_CYC     = 2,
   parameter int E_PULSE_US   = 1,
   parameter int EXEC_US      = 40,
   parameter int LONG_EXEC_US = 1640
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               init_done,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   rs,
   input  logic [8*N_REQ-1:0] data,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               done,
   output logic [4:0]         LCD_D,
   output logic               LCD_E
);

   localparam int T1US     = FREQ / 1000000;
   localparam int E_CYC    = E_PULSE_US * T1US;
   localparam int EXEC_CYC = EXEC_US * T1US;
   localparam int LONG_CYC = LONG_EXEC_US * T1US;
   localparam int CW       = $clog2(LONG_CYC + 1);
   localparam int PW       = $clog2(N_REQ);

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] E_LD     = CW'(E_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
   localparam logic [CW-1:0] LONG_LD  = CW'(LONG_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SET_H, S_E_H, S_HOLD_H, S_SET_L, S_E_L, S_HOLD_L, S_WAIT
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_ptr;
   logic             r_rs;
   logic [7:0]       r_byte;
   logic [N_REQ-1:0] r_grant;
   logic             r_busy;
   logic             r_done;
   logic [4:0]       r_lcd_d;
   logic             r_lcd_e;

   logic             w_pick_valid;
   logic [PW-1:0]    w_pick_idx;
   logic [PW-1:0]    w_cand;
   logic             w_long;
   logic [CW-1:0]    w_wait_ld;

   // Clear and return-home commands need the long execution wait.
   assign w_long    = (r_rs == 1'b0) && (r_byte >= 8'h01) && (r_byte <= 8'h03);
   assign w_wait_ld = w_long ? LONG_LD : EXEC_LD;

   // Round-robin pick: scan from the highest offset down so the nearest request at/after r_ptr wins.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand       = PW'((int'(r_ptr) + k >= N_REQ) ? int'(r_ptr) + k - N_REQ : int'(r_ptr) + k);
         w_pick_valid = w_pick_valid | req[w_cand];
         w_pick_idx   = req[w_cand] ? w_cand : w_pick_idx;
      end
   end

   // Transaction sequencer: arbitration, nibble timing, execution wait and all registered outputs.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_rs    <= 1'b0;
         r_byte  <= 8'h00;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lcd_d <= 5'b00000;
         r_lcd_e <= 1'b0;
      end else begin
         r_grant <= '0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (init_done && w_pick_valid) begin
                  r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                  r_rs    <= rs[w_pick_idx];
                  r_byte  <= data[8*w_pick_idx +: 8];
                  r_ptr   <= (w_pick_idx == PW'(N_REQ - 1)) ? '0 : w_pick_idx + PW'(1);
                  r_busy  <= 1'b1;
                  r_lcd_d <= {rs[w_pick_idx], data[8*w_pick_idx + 4 +: 4]};
                  r_lcd_e <= 1'b0;
                  r_cnt   <= SETUP_LD;
                  r_state <= S_SET_H;
               end else begin
                  r_busy  <= 1'b0;
                  r_lcd_d <= 5'b00000;
                  r_lcd_e <= 1'b0;
               end
            end
            S_SET_H, S_SET_L: begin
               if (r_cnt == '0) begin
                  r_lcd_e <= 1'b1;
                  r_cnt   <= E_LD;
                  r_state <= (r_state == S_SET_H) ? S_E_H : S_E_L;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_E_H, S_E_L: begin
               if (r_cnt == '0) begin
                  r_lcd_e <= 1'b0;
                  r_cnt   <= HOLD_LD;
                  r_state <= (r_state == S_E_H) ? S_HOLD_H : S_HOLD_L;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HOLD_H: begin
               if (r_cnt == '0) begin
                  r_lcd_d <= {r_rs, r_byte[3:0]};
                  r_cnt   <= SETUP_LD;
                  r_state <= S_SET_L;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HOLD_L: begin
               if (r_cnt == '0) begin
                  r_lcd_d <= 5'b00000;
                  r_cnt   <= w_wait_ld;
                  r_done  <= (w_wait_ld == '0);
                  r_state <= S_WAIT;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_WAIT: begin
               // done is raised on the edge that enters the final wait cycle.
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt  <= r_cnt - CW'(1);
                  r_done <= (r_cnt == CW'(1));
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_lcd_d <= 5'b00000;
               r_lcd_e <= 1'b0;
            end
         endcase
      end
   end

   assign grant = r_grant;
   assign busy  = r_busy;
   assign done  = r_done;
   assign LCD_D = r_lcd_d;
   assign LCD_E = r_lcd_e;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter: requesters push expected bytes per requester,
// a negedge monitor predicts grants round-robin and checks every output cycle by cycle.
`timescale 1ns/1ps
module tb_lcd_write_arbiter;

   localparam int FREQ     = 5000000;
   localparam int N        = 3;
   localparam int SETUP    = 2;
   localparam int HOLD     = 2;
   localparam int EPUS     = 1;
   localparam int EXUS     = 40;
   localparam int LGUS     = 1640;
   localparam int T1US     = FREQ / 1000000;
   localparam int ECYC     = EPUS * T1US;
   localparam int EXEC_CYC = EXUS * T1US;
   localparam int LONG_CYC = LGUS * T1US;
   localparam int NIB      = SETUP + ECYC + HOLD;
   localparam int TMO      = 20000;

   typedef struct packed {
      logic       rs;
      logic [7:0] d;
   } txn_t;

   logic         CLK;
   logic         reset;
   logic         init_done;
   logic [2:0]   req;
   logic [2:0]   rs;
   logic [23:0]  data;
   logic [2:0]   grant;
   logic         busy;
   logic         done;
   logic [4:0]   LCD_D;
   logic         LCD_E;

   int n_checks = 0;
   int n_fail   = 0;

   txn_t exp_q[3][$];
   int   grant_log[$];

   lcd_write_arbiter #(
      .FREQ(FREQ), .N_REQ(N), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD),
      .E_PULSE_US(EPUS), .EXEC_US(EXUS), .LONG_EXEC_US(LGUS)
   ) dut (
      .CLK(CLK), .reset(reset), .init_done(init_done), .req(req), .rs(rs), .data(data),
      .grant(grant), .busy(busy), .done(done), .LCD_D(LCD_D), .LCD_E(LCD_E)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   function automatic int rr_pick(input logic [2:0] pend, input int ptr);
      int j;
      for (int k = 0; k < N; k++) begin
         j = (ptr + k) % N;
         if (pend[j[1:0]]) return j;
      end
      return 0;
   endfunction

   // Expected {grant, busy, done, E, D} at cycle c after the grant edge.
   function automatic logic [10:0] exp_vec(input int c, input int last, input txn_t t, input logic [2:0] g);
      int p;
      logic [3:0] nib;
      logic [4:0] d;
      logic e;
      d = 5'b00000;
      e = 1'b0;
      if (c < 2 * NIB) begin
         p   = c % NIB;
         nib = (c < NIB) ? t.d[7:4] : t.d[3:0];
         d   = {t.rs, nib};
         e   = (p >= SETUP) && (p < SETUP + ECYC);
      end
      return {(c == 0) ? g : 3'b000, 1'b1, (c == last), e, d};
   endfunction

   // Requester protocol: raise request, hold until granted, drop one cycle later, then scramble inputs.
   task automatic send(input logic [1:0] idx, input logic r, input logic [7:0] d, input int dly);
      txn_t t;
      logic got;
      logic [31:0] rnd;
      cyc(1 + dly);
      t.rs = r;
      t.d  = d;
      exp_q[idx].push_back(t);
      rs[idx] = r;
      data[8*idx +: 8] = d;
      req[idx] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < TMO && !got; k++) begin
         cyc(1);
         got = grant[idx];
      end
      chk("grant_seen", 32'(got), 32'd1);
      cyc(1);
      rnd = $urandom;
      req[idx] = 1'b0;
      rs[idx] = rnd[0];
      data[8*idx +: 8] = rnd[8:1];
   endtask

   task automatic wait_idle();
      int quiet;
      quiet = 0;
      for (int k = 0; k < TMO && quiet < 3; k++) begin
         cyc(1);
         quiet = (!busy && req == 3'b000) ? quiet + 1 : 0;
      end
      chk("idle_reached", 32'(quiet), 32'd3);
   endtask

   // Monitor: predicts each grant from sampled requests and pointer, then checks every cycle.
   bit         active;
   bit         exp_next;
   int         c, last, m_ptr, idx;
   txn_t       cur;
   logic [2:0] cur_g, p_req, eg;
   initial begin
      active = 1'b0; exp_next = 1'b0; c = 0; last = 0; m_ptr = 0; idx = 0;
      cur = '0; cur_g = 3'b000; p_req = 3'b000; eg = 3'b000;
      forever begin
         @(negedge CLK);
         if (reset) begin
            chk("reset_outputs", 32'({grant, busy, done, LCD_E, LCD_D}), 32'd0);
            active = 1'b0; exp_next = 1'b0; m_ptr = 0;
         end else begin
            if (!active) begin
               if (grant != 3'b000) begin
                  idx = exp_next ? rr_pick(p_req, m_ptr) : (grant[0] ? 0 : (grant[1] ? 1 : 2));
                  eg  = exp_next ? (3'b001 << idx) : 3'b000;
                  chk("grant_select", 32'(grant), 32'(eg));
                  if (exp_q[idx].size() > 0) cur = exp_q[idx].pop_front();
                  else chk("queue_depth", 32'(exp_q[idx].size()), 32'd1);
                  cur_g = 3'b001 << idx;
                  last = 2 * NIB + ((!cur.rs && cur.d >= 8'h01 && cur.d <= 8'h03) ? LONG_CYC : EXEC_CYC) - 1;
                  m_ptr = (idx + 1) % N;
                  grant_log.push_back(idx);
                  active = 1'b1; c = 0; exp_next = 1'b0;
               end else begin
                  if (exp_next) chk("grant_latency", 32'(grant), 32'(3'b001 << rr_pick(p_req, m_ptr)));
                  chk("idle_outputs", 32'({busy, done, LCD_E, LCD_D}), 32'd0);
                  exp_next = init_done && (req != 3'b000);
                  p_req = req;
               end
            end
            if (active) begin
               chk("txn_wave", 32'({grant, busy, done, LCD_E, LCD_D}), 32'(exp_vec(c, last, cur, cur_g)));
               if (c == last) active = 1'b0;
               else c++;
            end
         end
      end
   end

   int         base, nlong, got2;
   int         exp3[5];
   logic [2:0] m;
   logic       rr[3];
   logic [7:0] dd[3];
   int         dl[3];
   initial begin
      exp3 = '{0, 1, 2, 0, 1};
      reset = 1'b1; init_done = 1'b0; req = 3'b000; rs = 3'b000; data = 24'h000000;
      cyc(5);
      chk("reset_state", 32'({grant, busy, done, LCD_E, LCD_D}), 32'd0);
      reset = 1'b0;
      init_done = 1'b1;
      cyc(2);

      // Single data byte 0x41.
      send(2'd0, 1'b1, 8'h41, 0);
      wait_idle();

      // Long clear command with a competing request arriving mid-transaction.
      fork
         send(2'd1, 1'b0, 8'h01, 0);
         send(2'd0, 1'b1, 8'h5A, 20);
      join
      wait_idle();

      // Request from 0 while 2 is being served.
      fork
         send(2'd2, 1'b1, 8'hC3, 0);
         begin
            got2 = 0;
            for (int k = 0; k < 100 && got2 == 0; k++) begin
               cyc(1);
               got2 = int'(grant[2]);
            end
            chk("grant2_for_overlap", 32'(got2), 32'd1);
            send(2'd0, 1'b0, 8'h38, 0);
         end
      join
      wait_idle();

      // No grant while init is incomplete, grant on the first edge after it completes.
      init_done = 1'b0;
      fork
         send(2'd2, 1'b1, 8'h7E, 0);
         begin
            cyc(200);
            chk("held_off_init", 32'({grant, LCD_E}), 32'd0);
            init_done = 1'b1;
            cyc(1);
            chk("grant_after_init", 32'(grant), 32'(3'b100));
         end
      join
      wait_idle();

      // Continuous requests: pointer starts at 0 here.
      base = grant_log.size();
      fork
         begin send(2'd0, 1'b1, 8'h11, 0); send(2'd0, 1'b1, 8'h22, 0); end
         begin send(2'd1, 1'b0, 8'h0C, 0); send(2'd1, 1'b1, 8'h33, 0); end
         send(2'd2, 1'b1, 8'h44, 0);
      join
      wait_idle();
      for (int k = 0; k < 5; k++)
         chk("rr_order", 32'(grant_log[base + k]), 32'(exp3[k]));

      // init_done falls mid-transaction: current byte finishes, nothing new is granted.
      fork
         send(2'd0, 1'b1, 8'h99, 0);
         begin cyc(10); init_done = 1'b0; end
      join
      fork
         send(2'd2, 1'b1, 8'hA5, 0);
         begin
            cyc(2 * NIB + EXEC_CYC + 100);
            chk("no_grant_init_low", 32'({busy, LCD_E}), 32'd0);
            init_done = 1'b1;
         end
      join
      wait_idle();

      // Reset during the high-nibble E pulse.
      send(2'd1, 1'b1, 8'hF0, 0);
      cyc(1);
      #1;
      chk("e_high_before_reset", 32'(LCD_E), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_reset", 32'({LCD_E, busy}), 32'd0);
      cyc(2);
      #1;
      reset = 1'b0;
      base = grant_log.size();
      fork
         send(2'd0, 1'b1, 8'h30, 0);
         send(2'd1, 1'b1, 8'h31, 0);
      join
      wait_idle();
      chk("reset_rr_first", 32'(grant_log[base]), 32'd0);

      // Randomized batches.
      nlong = 0;
      for (int it = 0; it < 12; it++) begin
         m = 3'($urandom_range(1, 7));
         for (int i = 0; i < N; i++) begin
            rr[i] = 1'($urandom_range(0, 1));
            dd[i] = 8'($urandom_range(0, 255));
            dl[i] = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0 && nlong < 2) begin
               rr[i] = 1'b0;
               dd[i] = 8'($urandom_range(1, 3));
            end
            if (m[i] && !rr[i] && dd[i] >= 8'h01 && dd[i] <= 8'h03) nlong++;
         end
         fork
            begin if (m[0]) send(2'd0, rr[0], dd[0], dl[0]); end
            begin if (m[1]) send(2'd1, rr[1], dd[1], dl[1]); end
            begin if (m[2]) send(2'd2, rr[2], dd[2], dl[2]); end
         join
         wait_idle();
      end

      cyc(5);
      for (int i = 0; i < N; i++)
         chk("queue_drained", 32'(exp_q[i].size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
